// File: rtl/host_transmitter.sv
// Frames one request as [opcode][payload MSB first][optional XOR checksum] into the TX FIFO.
// Optional feature: define TX_CHECKSUM_EN to append the checksum byte.
module host_transmitter #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned PAYLOAD_BYTES  = 4,
  parameter int unsigned TX_FIFO_SIZE   = 1024,
  parameter int unsigned TX_FIFO_LOAD_W = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [7:0]                 req_opcode,
  input  logic [8*PAYLOAD_BYTES-1:0] req_data,
  output logic                       busy,
  output logic [15:0]                frames_sent,
  input  logic [TX_FIFO_LOAD_W-1:0]  txfifo_load,
  input  logic                       txfifo_full,
  output logic                       txfifo_wr,
  output logic [DATA_W-1:0]          txfifo_data
);

  localparam int unsigned PAY_W = 8 * PAYLOAD_BYTES;
`ifdef TX_CHECKSUM_EN
  localparam int unsigned CSUM_LEN = 1;
`else
  localparam int unsigned CSUM_LEN = 0;
`endif
  localparam int unsigned FRAME_LEN = 1 + PAYLOAD_BYTES + CSUM_LEN;
  localparam int unsigned IDX_W     = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_CHECKSUM,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [7:0]         r_opcode;
  logic [PAY_W-1:0]   r_shift;
  logic [IDX_W-1:0]   r_idx;
  logic [15:0]        r_frames;
  logic               w_free_ok;
  logic               w_accept;
  logic               w_emit;
  logic               w_wr;
  logic               w_last;
  logic [DATA_W-1:0]  w_byte;

`ifdef TX_CHECKSUM_EN
  logic [7:0] r_csum;

  function automatic logic [7:0] frame_xor(input logic [7:0] op, input logic [PAY_W-1:0] d);
    logic [7:0] acc;
    acc = op;
    for (int i = 0; i < int'(PAYLOAD_BYTES); i++) acc = acc ^ d[8*i +: 8];
    return acc;
  endfunction
`endif

  // Space is reserved for the whole frame at acceptance, so the full gate rarely fires.
  assign w_free_ok = (32'(txfifo_load) + FRAME_LEN) <= TX_FIFO_SIZE;
  assign req_ready = (r_state == S_IDLE) & w_free_ok & ~rst;
  assign w_accept  = req_valid & req_ready;
  assign w_emit    = (r_state == S_HEADER) | (r_state == S_PAYLOAD) | (r_state == S_CHECKSUM);
  assign w_wr      = w_emit & ~txfifo_full & ~rst;
  assign w_last    = r_idx == IDX_W'(PAYLOAD_BYTES - 1);

  assign txfifo_wr   = w_wr;
  assign txfifo_data = w_byte;
  assign busy        = r_state != S_IDLE;
  assign frames_sent = r_frames;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and the byte presented to the FIFO; the byte only changes on an accepted write.
  always_comb begin
    w_next = r_state;
    w_byte = '0;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_HEADER;
      S_HEADER: begin
        w_byte = DATA_W'(r_opcode);
        if (w_wr) w_next = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        w_byte = DATA_W'(r_shift[PAY_W-1 -: 8]);
`ifdef TX_CHECKSUM_EN
        if (w_wr && w_last) w_next = S_CHECKSUM;
`else
        if (w_wr && w_last) w_next = S_DONE;
`endif
      end
`ifdef TX_CHECKSUM_EN
      S_CHECKSUM: begin
        w_byte = DATA_W'(r_csum);
        if (w_wr) w_next = S_DONE;
      end
`endif
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_opcode <= '0;
      r_shift  <= '0;
      r_idx    <= '0;
      r_frames <= '0;
`ifdef TX_CHECKSUM_EN
      r_csum   <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_opcode <= req_opcode;
        r_shift  <= req_data;
        r_idx    <= '0;
`ifdef TX_CHECKSUM_EN
        r_csum   <= frame_xor(req_opcode, req_data);
`endif
      end else if (w_wr && (r_state == S_PAYLOAD)) begin
        r_shift <= r_shift << 8;
        r_idx   <= r_idx + IDX_W'(1);
      end
      if (r_state == S_DONE) r_frames <= r_frames + 16'd1;
    end
  end

endmodule
